alu_multicycle: RTL and testbench

- Execute-stage ALU; consumes the 3-bit ALU control code from the ALU control decoder plus two register operands.
- AND/OR/ADD/SUB/SLT complete in one cycle.
- MUL runs on an iterative shift-add datapath under a start/busy/done handshake.
- Drives the writeback result register and the zero flag used by branch compare.

---
 rtl/alu_multicycle.sv | 132 +++++++++++++
 tb/tb_alu_multicycle.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus an iterative shift-add MUL.
// Define MUL_EARLY_TERM_EN to let MUL finish as soon as the remaining multiplier bits are all zero.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             state_o
);

    // Handshake: start_i is accepted on a rising edge only while busy_o is low (operands are
    // captured on that edge); done_o is a one-cycle pulse during which data_o holds the result.

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    state_t           state, state_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] acc_step;
    logic             mul_last;

    always_comb begin
        single_res = '0;
        case (ALUCtrl_i)
            OP_AND:  single_res = data1_i & data2_i;
            OP_OR:   single_res = data1_i | data2_i;
            OP_ADD:  single_res = data1_i + data2_i;
            OP_SUB:  single_res = data1_i - data2_i;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default: single_res = '0;
        endcase
    end

    // One shift-add step; acc_step is the accumulator value after this edge's add.
    always_comb begin
        acc_step = mplier[0] ? acc + mcand : acc;
`ifdef MUL_EARLY_TERM_EN
        mul_last = (cnt + 1'b1 == CNT_W'(WIDTH)) || ((mplier >> 1) == '0);
`else
        mul_last = (cnt + 1'b1 == CNT_W'(WIDTH));
`endif
    end

    always_comb begin
        state_n  = state;
        data_n   = data_q;
        done_n   = 1'b0;
        mcand_n  = mcand;
        mplier_n = mplier;
        acc_n    = acc;
        cnt_n    = cnt;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (ALUCtrl_i == OP_MUL) begin
                        mcand_n  = data1_i;
                        mplier_n = data2_i;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = MUL;
                    end else begin
                        data_n = single_res;
                        done_n = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + 1'b1;
                if (mul_last) begin
                    data_n  = acc_step;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            data_q <= '0;
            done_q <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            done_q <= done_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
        end
    end

    assign data_o  = data_q;
    assign zero_o  = (data_q == '0);
    assign busy_o  = (state == MUL);
    assign done_o  = done_q;
    assign state_o = state;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table, multi-cycle corner sequences, random ops.
module tb_alu_multicycle;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] data_o;
    logic             zero_o, busy_o, done_o, state_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] exp_q[$];

    alu_multicycle #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(ctrl),
        .data1_i(a), .data2_i(b), .data_o(data_o), .zero_o(zero_o),
        .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       c;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] c, input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        longint unsigned prod;
        case (c)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x + y;
            3'd3: begin
                prod = longint'(x) * longint'(y);
                return prod[WIDTH-1:0];
            end
            3'd6: return x - y;
            3'd7: return (int'(x) < int'(y)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // Edges after the accepting edge until done_o is visible (0 for single-cycle ops).
    function automatic int ref_latency(input logic [2:0] c, input logic [WIDTH-1:0] y);
        int top;
        if (c != 3'd3) return 0;
`ifdef MUL_EARLY_TERM_EN
        top = 0;
        for (int i = 0; i < WIDTH; i++) if (y[i]) top = i + 1;
        return (top < 1) ? 1 : top;
`else
        return WIDTH;
`endif
    endfunction

    task automatic launch(input logic [2:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        start = 1'b1; ctrl = c; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; ctrl = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic run_op(input logic [2:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input string tag);
        logic [WIDTH-1:0] exp;
        int lat;
        exp = ref_result(c, x, y);
        launch(c, x, y);
        lat = 0;
        while (!done_o && lat < WIDTH + 4) begin
            check({tag, "_busy"}, busy_o, 1);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done"}, done_o, 1);
        check({tag, "_latency"}, lat, ref_latency(c, y));
        check({tag, "_data"}, data_o, exp);
        check({tag, "_zero"}, zero_o, (exp == 0));
        check({tag, "_busy_end"}, busy_o, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done_o, 0);
        check({tag, "_hold"}, data_o, exp);
    endtask

    vec_t vecs[12];
    int   dcount;
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] x, y;
    logic [WIDTH-1:0] big_b;

    initial begin
        vecs[0]  = '{3'd2, 32'd5, 32'd7, 32'd12};
        vecs[1]  = '{3'd6, 32'd3, 32'd3, 32'd0};
        vecs[2]  = '{3'd7, 32'hFFFF_FFFF, 32'd1, 32'd1};
        vecs[3]  = '{3'd7, 32'd1, 32'hFFFF_FFFF, 32'd0};
        vecs[4]  = '{3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        vecs[5]  = '{3'd1, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11};
        vecs[6]  = '{3'd4, 32'd9, 32'd9, 32'd0};
        vecs[7]  = '{3'd5, 32'd1, 32'd2, 32'd0};
        vecs[8]  = '{3'd3, 32'd6, 32'd7, 32'd42};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
        vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'd1, 32'd0};
        vecs[11] = '{3'd3, 32'd9, 32'd0, 32'd0};
        big_b = 32'h8000_0007;   // 6*big_b truncates to 42 and runs a full-length MUL in either build

        rst = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
        #1;
        check("reset_data", data_o, 0);
        check("reset_zero", zero_o, 1);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_state", state_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d_model", i), ref_result(vecs[i].c, vecs[i].x, vecs[i].y), vecs[i].exp);
            run_op(vecs[i].c, vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
        end

        // ADD request at edge N+5 of a MUL must be ignored.
        launch(3'd3, 32'd6, big_b);
        dcount = 0; got = '0;
        for (int k = 1; k <= WIDTH + 5; k++) begin
            if (k == 5) begin start = 1'b1; ctrl = 3'd2; a = 32'd1; b = 32'd1; end
            @(posedge clk); #1;
            if (k == 5) start = 1'b0;
            if (done_o) begin dcount++; got = data_o; check("ign_done_edge", k, WIDTH); end
        end
        check("ign_done_count", dcount, 1);
        check("ign_data", got, 32'd42);

        // start held high through the finishing edge: ignored there, accepted the edge after.
        @(negedge clk);
        start = 1'b1; ctrl = 3'd3; a = 32'd6; b = big_b;
        @(posedge clk); #1;
        ctrl = 3'd2; a = 32'd1; b = 32'd1;
        for (int k = 1; k < WIDTH; k++) begin
            @(posedge clk); #1;
            check("held_busy", busy_o, 1);
            check("held_nodone", done_o, 0);
        end
        @(posedge clk); #1;
        check("held_fin_done", done_o, 1);
        check("held_fin_data", data_o, 32'd42);
        @(posedge clk); #1;
        start = 1'b0;
        check("held_add_done", done_o, 1);
        check("held_add_data", data_o, 32'd2);
        @(posedge clk); #1;
        check("held_add_pulse", done_o, 0);

        // Reset at edge N+10 of a MUL.
        launch(3'd3, 32'd6, big_b);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_data", data_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_zero", zero_o, 1);
        check("rstmid_done", done_o, 0);
        @(negedge clk); rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(posedge clk); #1;
            if (done_o) dcount++;
        end
        check("rstmid_no_done", dcount, 0);
        run_op(3'd2, 32'd2, 32'd2, "post_rst_add");

        // Back-to-back single-cycle ops with start held high.
        @(negedge clk);
        x = $urandom; y = $urandom;
        start = 1'b1; ctrl = 3'd2; a = x; b = y;
        exp_q.push_back(ref_result(3'd2, x, y));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("b2b_done", done_o, 1);
            check("b2b_data", data_o, exp_q.pop_front());
            if (i < 5) begin
                x = $urandom; y = $urandom;
                ctrl = (i % 2 == 0) ? 3'd6 : 3'd7;
                a = x; b = y;
                exp_q.push_back(ref_result(ctrl, x, y));
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("b2b_idle", done_o, 0);

        // Random operations, including reserved codes and sparse multipliers.
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 3 == 0) y = y >> $urandom_range(0, WIDTH - 1);
            run_op(3'($urandom_range(0, 7)), x, y, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
